// File: rtl/myfilter_pkg.sv
// Shared filter package: sample width, output FIFO defaults, sample/tag types.
// Imported by the filter datapath and the output sample FIFO.
package myfilter_pkg;

  localparam int DATABITS = 12;

  localparam int OUTFIFO_DEPTH = 16;
  localparam int OUTFIFO_AFULL = 12;

  typedef logic [DATABITS-1:0] sample_t;
  typedef logic [7:0] seq_tag_t;

endpackage

// File: rtl/sample_out_fifo_mem.sv
// Simple dual-port register array: one clocked write port, async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Contents not reset.
module sample_out_fifo_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_out_fifo.sv
// Output sample FIFO: captures filter samples, FWFT ready/valid out, status.
// Ports: clk, rst_n, ext_in/extvalid_in, clr_in, dout/dvalid_out/dready_in,
// level_out, almost_full_out, overflow_out; tag_out with SAMPLE_OUT_FIFO_TAG_EN.
module sample_out_fifo
  import myfilter_pkg::*;
#(
  parameter int DEPTH       = OUTFIFO_DEPTH,
  parameter int AFULL_LEVEL = OUTFIFO_AFULL
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  sample_t                      ext_in,
  input  logic                         extvalid_in,
  input  logic                         clr_in,
  output sample_t                      dout,
  output logic                         dvalid_out,
  input  logic                         dready_in,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic                         almost_full_out,
  output logic                         overflow_out
`ifdef SAMPLE_OUT_FIFO_TAG_EN
  ,
  output seq_tag_t                     tag_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_LEVEL);

`ifdef SAMPLE_OUT_FIFO_TAG_EN
  localparam int MW = DATABITS + 8;
`else
  localparam int MW = DATABITS;
`endif

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow;
  logic          push;
  logic          pop;
  logic [MW-1:0] wdata;
  logic [MW-1:0] rdata;

  // Status is decoded from the level register only, so no
  // combinational path exists from extvalid_in to these flags.
  assign dvalid_out      = (level != '0);
  assign almost_full_out = (level >= AF_LVL);
  assign level_out       = level;
  assign overflow_out    = overflow;

  assign pop  = dvalid_out && dready_in;
  // A full FIFO still accepts when the head leaves this cycle.
  assign push = extvalid_in && ((level < FULL_LVL) || pop);

  assign dout = dvalid_out ? rdata[DATABITS-1:0] : '0;

`ifdef SAMPLE_OUT_FIFO_TAG_EN
  seq_tag_t seq;

  // Counts every offered sample, dropped or not, so drops show as gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (extvalid_in) begin
      seq <= seq + 8'd1;
    end
  end

  assign wdata   = {seq, ext_in};
  assign tag_out = dvalid_out ? rdata[DATABITS +: 8] : '0;
`else
  assign wdata = ext_in;
`endif

  sample_out_fifo_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clr_in),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clr_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (extvalid_in && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_out_fifo.sv
// Self-checking bench for sample_out_fifo against a queue-based model.
// Tag scenario runs only when SAMPLE_OUT_FIFO_TAG_EN is defined.
module tb_sample_out_fifo;
  import myfilter_pkg::*;

  localparam int D  = OUTFIFO_DEPTH;
  localparam int AF = OUTFIFO_AFULL;
  localparam int LW = $clog2(D + 1);
  localparam int VW = DATABITS + LW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  sample_t       ext_in = '0;
  logic          extvalid_in = 1'b0;
  logic          clr_in = 1'b0;
  logic          dready_in = 1'b0;
  sample_t       dout;
  logic          dvalid_out;
  logic [LW-1:0] level_out;
  logic          almost_full_out;
  logic          overflow_out;
`ifdef SAMPLE_OUT_FIFO_TAG_EN
  seq_tag_t      tag_out;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATABITS+7:0] q[$];
  logic                m_ovf = 1'b0;
  logic [7:0]          m_tag = '0;

  always #5 clk = ~clk;

  sample_out_fifo dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ext_in          (ext_in),
    .extvalid_in     (extvalid_in),
    .clr_in          (clr_in),
    .dout            (dout),
    .dvalid_out      (dvalid_out),
    .dready_in       (dready_in),
    .level_out       (level_out),
    .almost_full_out (almost_full_out),
    .overflow_out    (overflow_out)
`ifdef SAMPLE_OUT_FIFO_TAG_EN
    ,
    .tag_out         (tag_out)
`endif
  );

  function automatic logic [VW-1:0] exp_vec();
    sample_t d;
    logic    v;
    d = '0;
    v = (q.size() > 0);
    if (v) d = q[0][DATABITS-1:0];
    return {d, v, LW'(q.size()), (q.size() >= AF), m_ovf};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {dout, dvalid_out, level_out, almost_full_out, overflow_out};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_tag = '0;
  endfunction

  // Drives one cycle, advances the model by the FIFO rules, settles #1.
  task automatic cycle(input logic ev, input sample_t d,
                       input logic rdy, input logic clr);
    logic pop;
    logic push;
    ext_in      = d;
    extvalid_in = ev;
    dready_in   = rdy;
    clr_in      = clr;
    @(posedge clk);
    pop  = (q.size() > 0) && rdy;
    push = ev && ((q.size() < D) || pop);
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_tag, d});
      if (ev && !push) m_ovf = 1'b1;
    end
    if (ev) m_tag = m_tag + 8'd1;
    #1;
    extvalid_in = 1'b0;
    clr_in      = 1'b0;
    dready_in   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", obs_vec());
    end
    rst_n = 1'b1;
    model_reset();
    #4;
  endtask

  task automatic test_basic();
    sample_t want [3];
    want[0] = 12'h011;
    want[1] = 12'h022;
    want[2] = 12'h033;
    for (int i = 0; i < 3; i++) cycle(1'b1, want[i], 1'b0, 1'b0);
    checks++;
    if (level_out !== LW'(3) || dout !== 12'h011 || dvalid_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: got lvl=%0d dout=%h v=%b want 3 011 1",
               level_out, dout, dvalid_out);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout !== want[i] || dvalid_out !== 1'b1) begin
        errors++;
        $display("FAIL basic_read%0d: got %h v=%b want %h", i, dout,
                 dvalid_out, want[i]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (dvalid_out !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL basic_empty: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    sample_t sd [18];
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      sd[i] = sample_t'($urandom);
      cycle(1'b1, sd[i], 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() ||
          almost_full_out !== (i + 1 >= AF) ||
          overflow_out !== (i + 1 >= D + 1)) begin
        errors++;
        $display("FAIL fill_push%0d: got %h want %h", i + 1, obs_vec(),
                 exp_vec());
      end
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (dout !== sd[i] || dvalid_out !== 1'b1) begin
        errors++;
        $display("FAIL fill_read%0d: got %h want %h", i, dout, sd[i]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (obs_vec() !== exp_vec() || level_out !== '0) begin
      errors++;
      $display("FAIL fill_drained: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_stream();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) cycle(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, sample_t'($urandom), 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || level_out !== LW'(D) ||
          overflow_out !== 1'b0) begin
        errors++;
        $display("FAIL full_stream%0d: got %h want %h", i, obs_vec(),
                 exp_vec());
      end
    end
  endtask

  task automatic test_clr();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < D + 1; i++) cycle(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < D - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (level_out !== LW'(5) || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got lvl=%0d ovf=%b want 5 1", level_out,
               overflow_out);
    end
    cycle(1'b1, 12'h7E7, 1'b0, 1'b1);
    checks++;
    if (level_out !== '0 || dvalid_out !== 1'b0 || overflow_out !== 1'b0 ||
        obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clr_flush: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    ext_in      = sample_t'($urandom);
    extvalid_in = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", obs_vec());
    end
    extvalid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle(1'b1, 12'h5A5, 1'b0, 1'b0);
    checks++;
    if (dout !== 12'h5A5 || dvalid_out !== 1'b1 || level_out !== LW'(1)) begin
      errors++;
      $display("FAIL async_after: got %h v=%b lvl=%0d want 5a5 1 1", dout,
               dvalid_out, level_out);
    end
  endtask

  task automatic test_random();
    logic ev;
    logic rdy;
    logic clr;
    for (int i = 0; i < 400; i++) begin
      ev  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 99) < 2);
      cycle(ev, sample_t'($urandom), rdy, clr);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef SAMPLE_OUT_FIFO_TAG_EN
  task automatic test_tag();
    #2;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < D; i++) begin
      checks++;
      if (tag_out !== 8'(i) || tag_out !== q[0][DATABITS +: 8] ||
          dout !== q[0][DATABITS-1:0]) begin
        errors++;
        $display("FAIL tag_read%0d: got %h/%h want %h", i, tag_out, dout,
                 q[0]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    cycle(1'b1, 12'h123, 1'b0, 1'b0);
    checks++;
    if (tag_out !== 8'd20 || dout !== 12'h123) begin
      errors++;
      $display("FAIL tag_next: got %h/%h want 14/123", tag_out, dout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_stream();
    test_clr();
    test_async_reset();
    test_random();
`ifdef SAMPLE_OUT_FIFO_TAG_EN
    test_tag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
